// File: rtl/traffic_light_monitor.sv
// Passive checker for a RED->GREEN->YELLOW lamp sequence: one-hot, order and dwell rules.
// Define TL_MON_DWELL_CHECK_EN to compile in the per-phase dwell counter and err_dwell.
module traffic_light_monitor #(
    parameter int unsigned RED_CYCLES    = 10,
    parameter int unsigned GREEN_CYCLES  = 10,
    parameter int unsigned YELLOW_CYCLES = 5,
    parameter int unsigned DWELL_W       = 8,
    parameter int unsigned ERRCNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lamp_red,
    input  logic                lamp_green,
    input  logic                lamp_yellow,
    input  logic                clr_err,
    output logic                synced,
    output logic [1:0]          phase,
    output logic                phase_done,
    output logic                err_onehot,
    output logic                err_order,
    output logic                err_dwell,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [15:0]         cycle_count
);

    typedef enum logic [1:0] {
        PH_RED     = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10,
        PH_INVALID = 2'b11
    } phase_t;

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } state_t;

    if (RED_CYCLES < 2 || GREEN_CYCLES < 2 || YELLOW_CYCLES < 2 ||
        RED_CYCLES + 1 >= (64'd1 << DWELL_W) || GREEN_CYCLES + 1 >= (64'd1 << DWELL_W) ||
        YELLOW_CYCLES + 1 >= (64'd1 << DWELL_W) || ERRCNT_W < 1) begin : g_bad_cfg
        $error("traffic_light_monitor: phase lengths must be >= 2 and fit DWELL_W with one to spare");
    end

    state_t state;
    phase_t prev_ph, cur_ph, succ_ph;
    logic   valid_now, change, tracked_change;
    logic   e_onehot, e_order, e_dwell, any_err;

    always_comb begin
        cur_ph = PH_INVALID;
        case ({lamp_red, lamp_green, lamp_yellow})
            3'b100:  cur_ph = PH_RED;
            3'b010:  cur_ph = PH_GREEN;
            3'b001:  cur_ph = PH_YELLOW;
            default: cur_ph = PH_INVALID;
        endcase
        succ_ph = PH_INVALID;
        case (prev_ph)
            PH_RED:    succ_ph = PH_GREEN;
            PH_GREEN:  succ_ph = PH_YELLOW;
            PH_YELLOW: succ_ph = PH_RED;
            default:   succ_ph = PH_INVALID;
        endcase
    end

    assign valid_now      = (cur_ph != PH_INVALID);
    assign change         = valid_now && (prev_ph != PH_INVALID) && (cur_ph != prev_ph);
    assign tracked_change = (state == TRACK) && change;
    assign e_onehot       = !valid_now;
    assign e_order        = tracked_change && (cur_ph != succ_ph);
    assign any_err        = e_onehot || e_order || e_dwell;

`ifdef TL_MON_DWELL_CHECK_EN
    logic [DWELL_W-1:0] dwell, dwell_nxt, req_len;
    logic               same;

    // Long dwell fires on the step from req_len to req_len+1 only; a short one at the phase change.
    always_comb begin
        req_len = '0;
        case (prev_ph)
            PH_RED:    req_len = DWELL_W'(RED_CYCLES);
            PH_GREEN:  req_len = DWELL_W'(GREEN_CYCLES);
            PH_YELLOW: req_len = DWELL_W'(YELLOW_CYCLES);
            default:   req_len = '0;
        endcase
        same      = valid_now && (cur_ph == prev_ph);
        dwell_nxt = '0;
        if (same)
            dwell_nxt = (dwell == '1) ? dwell : dwell + DWELL_W'(1);
        else if (valid_now)
            dwell_nxt = DWELL_W'(1);
        e_dwell = (state == TRACK) && ((same && dwell == req_len) || (change && dwell < req_len));
    end
`else
    assign e_dwell   = 1'b0;
    assign err_dwell = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UNSYNC;
            prev_ph     <= PH_INVALID;
            phase_done  <= 1'b0;
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
            err_count   <= '0;
            cycle_count <= '0;
`ifdef TL_MON_DWELL_CHECK_EN
            dwell       <= '0;
            err_dwell   <= 1'b0;
`endif
        end else begin
            prev_ph    <= cur_ph;
            phase_done <= tracked_change;
            if (!valid_now)
                state <= UNSYNC;
            else if (change)
                state <= TRACK;
            if (tracked_change && prev_ph == PH_YELLOW && cur_ph == PH_RED)
                cycle_count <= cycle_count + 16'd1;
            err_onehot <= (err_onehot && !clr_err) || e_onehot;
            err_order  <= (err_order && !clr_err) || e_order;
            if (clr_err)
                err_count <= any_err ? ERRCNT_W'(1) : '0;
            else if (any_err && err_count != '1)
                err_count <= err_count + ERRCNT_W'(1);
`ifdef TL_MON_DWELL_CHECK_EN
            dwell     <= dwell_nxt;
            err_dwell <= (err_dwell && !clr_err) || e_dwell;
`endif
        end
    end

    assign phase  = prev_ph;
    assign synced = (state == TRACK);

endmodule
